vie_mem_bus_arbiter: RTL and testbench

- Shares one SRAM-like memory bus between the fetch requester (inst) and the load/store requester (data).
- The data requester is the load/store path that feeds the mem stage; its returned word is what the mem stage byte-selects.
- Tracks outstanding accepted requests in order and routes each bus_data_ok back to the requester that issued it.
- Sits between the pipeline front/execute stages and the external bus.

---
 rtl/vie_mem_bus_arbiter_pkg.sv | 24 ++
 rtl/vie_mem_bus_arbiter_src_fifo.sv | 68 ++++++
 rtl/vie_mem_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_vie_mem_bus_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vie_mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vie_mem_bus_arbiter_pkg
// Description : Shared encodings for the inst/data memory bus arbiter:
//               FSM states, request source codes and bus size codes.
// Revision    : 1.0 - initial release
// ============================================================================
package vie_mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    VIE_ARB_IDLE   = 2'd0,
    VIE_ARB_LOCK_I = 2'd1,
    VIE_ARB_LOCK_D = 2'd2
  } vie_arb_state_e;

  localparam logic C_VIE_SRC_INST = 1'b0;
  localparam logic C_VIE_SRC_DATA = 1'b1;

  localparam logic [1:0] C_VIE_SIZE_BYTE = 2'd0;
  localparam logic [1:0] C_VIE_SIZE_HALF = 2'd1;
  localparam logic [1:0] C_VIE_SIZE_WORD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/vie_mem_bus_arbiter_src_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vie_src_fifo
// Description : 1-bit wide circular FIFO recording which requester issued
//               each accepted bus transaction. Depth need not be a power of 2.
// Revision    : 1.0 - initial release
// ============================================================================
module vie_src_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_push,
  input  logic i_din,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output logic o_head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // legal only alongside a pop.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // Storage, pointer and occupancy update.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= f_next(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= f_next(r_rptr);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vie_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vie_mem_bus_arbiter
// Description : Shares one SRAM-like bus between the fetch (inst) and
//               load/store (data) requesters, tracks outstanding requests in
//               order and routes each response back to its issuer.
//               Optional macro VIE_ARB_RR_EN: round-robin grant when both
//               requesters are pending in IDLE (default: data priority).
// Revision    : 1.0 - initial release
// ============================================================================
module vie_mem_bus_arbiter
  import vie_mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_OUT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [DW-1:0] inst_rdata,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [DW-1:0] data_rdata,
  output logic          bus_req,
  output logic          bus_wr,
  output logic [1:0]    bus_size,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_addr_ok,
  input  logic          bus_data_ok,
  input  logic [DW-1:0] bus_rdata
);

  vie_arb_state_e r_state;
  vie_arb_state_e w_next_state;
  logic           w_issue;
  logic           w_src;
  logic           w_pick;
  logic           w_accept;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic           w_head;

`ifdef VIE_ARB_RR_EN
  logic r_last;

  // Both pending: the port not granted last wins; otherwise whoever asks.
  assign w_pick = (inst_req && data_req) ? ~r_last : data_req;

  // Remember the source of each accepted request for the next tie-break.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last <= C_VIE_SRC_INST;
    end else if (w_accept) begin
      r_last <= w_src;
    end
  end
`else
  assign w_pick = data_req ? C_VIE_SRC_DATA : C_VIE_SRC_INST;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= VIE_ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Grant selection and next state; a lock pins the grant until accepted.
  always_comb begin
    w_issue      = 1'b0;
    w_src        = C_VIE_SRC_INST;
    w_next_state = r_state;
    case (r_state)
      VIE_ARB_IDLE: begin
        if (!w_full && (inst_req || data_req)) begin
          w_issue = 1'b1;
          w_src   = w_pick;
          if (!bus_addr_ok) begin
            w_next_state = w_pick ? VIE_ARB_LOCK_D : VIE_ARB_LOCK_I;
          end
        end
      end
      VIE_ARB_LOCK_I: begin
        w_issue = 1'b1;
        w_src   = C_VIE_SRC_INST;
        if (bus_addr_ok) w_next_state = VIE_ARB_IDLE;
      end
      VIE_ARB_LOCK_D: begin
        w_issue = 1'b1;
        w_src   = C_VIE_SRC_DATA;
        if (bus_addr_ok) w_next_state = VIE_ARB_IDLE;
      end
      default: begin
        w_next_state = VIE_ARB_IDLE;
      end
    endcase
  end

  // Requests are suppressed while reset is held so the bus sees nothing.
  assign bus_req   = w_issue & reset;
  assign bus_addr  = w_src ? data_addr : inst_addr;
  assign bus_wr    = w_src & data_wr;
  assign bus_size  = w_src ? data_size : C_VIE_SIZE_WORD;
  assign bus_wdata = w_src ? data_wdata : '0;

  assign w_accept     = bus_req & bus_addr_ok;
  assign inst_addr_ok = w_accept & (w_src == C_VIE_SRC_INST);
  assign data_addr_ok = w_accept & (w_src == C_VIE_SRC_DATA);

  // Responses with nothing outstanding are dropped.
  assign w_pop        = bus_data_ok & ~w_empty;
  assign inst_data_ok = w_pop & (w_head == C_VIE_SRC_INST);
  assign data_data_ok = w_pop & (w_head == C_VIE_SRC_DATA);
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  vie_src_fifo #(
    .DEPTH (MAX_OUT)
  ) u_src_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_accept),
    .i_din   (w_src),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

endmodule
`default_nettype wire

// File: tb/tb_vie_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vie_mem_bus_arbiter
// Description : Self-checking bench for vie_mem_bus_arbiter: directed
//               scenarios followed by randomized traffic, all checked against
//               a queue-based reference model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vie_mem_bus_arbiter;

  localparam int MAX_OUT = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
`ifdef VIE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_addr_ok;
  logic          inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic          data_req;
  logic          data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          bus_req;
  logic          bus_wr;
  logic [1:0]    bus_size;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_addr_ok;
  logic          bus_data_ok;
  logic [DW-1:0] bus_rdata;

  always #5 clock = ~clock;

  vie_mem_bus_arbiter #(.MAX_OUT(MAX_OUT), .AW(AW), .DW(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_size     (bus_size),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: outstanding sources in acceptance order, the source a
  // pending un-accepted grant is pinned to (-1 = none), and last accepted.
  bit mq[$];
  int mlock = -1;
  bit mlast = 1'b0;

  // Observed outputs captured during the last step, for directed checks.
  logic          c_bus_req, c_inst_addr_ok, c_data_addr_ok;
  logic          c_inst_data_ok, c_data_data_ok;
  logic [AW-1:0] c_bus_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Evaluate one cycle: inputs are already applied; compare outputs with the
  // model, then advance the model across the rising edge.
  task automatic step(input string tag);
    bit issue, src, accept, pop, head;
    #1;
    issue = 1'b0;
    src   = 1'b0;
    if (reset && mlock >= 0) begin
      issue = 1'b1;
      src   = mlock[0];
    end else if (reset && mq.size() < MAX_OUT && (inst_req || data_req)) begin
      issue = 1'b1;
      if (inst_req && data_req) src = RR ? ~mlast : 1'b1;
      else                      src = data_req;
    end
    accept = issue & bus_addr_ok;
    pop    = reset & bus_data_ok & (mq.size() > 0);
    head   = (mq.size() > 0) ? mq[0] : 1'b0;

    chk({tag, ".bus_req"}, 64'(bus_req), 64'(issue));
    if (issue) begin
      chk({tag, ".bus_addr"}, 64'(bus_addr), 64'(src ? data_addr : inst_addr));
      chk({tag, ".bus_wr_size"}, 64'({bus_wr, bus_size}),
          64'(src ? {data_wr, data_size} : 3'b010));
      if (src) chk({tag, ".bus_wdata"}, 64'(bus_wdata), 64'(data_wdata));
    end
    chk({tag, ".addr_ok"}, 64'({inst_addr_ok, data_addr_ok}),
        64'({accept & ~src, accept & src}));
    chk({tag, ".data_ok"}, 64'({inst_data_ok, data_data_ok}),
        64'({pop & ~head, pop & head}));
    chk({tag, ".rdata"}, {inst_rdata, data_rdata}, {bus_rdata, bus_rdata});

    c_bus_req      = bus_req;
    c_inst_addr_ok = inst_addr_ok;
    c_data_addr_ok = data_addr_ok;
    c_inst_data_ok = inst_data_ok;
    c_data_data_ok = data_data_ok;
    c_bus_addr     = bus_addr;

    @(posedge clock);
    if (!reset) begin
      mq.delete();
      mlock = -1;
      mlast = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (accept) begin
        mq.push_back(src);
        mlast = src;
        mlock = -1;
      end else if (issue) begin
        mlock = int'(src);
      end
    end
    @(negedge clock);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    step("rst");
    reset = 1'b1;
  endtask

  initial begin
    bit ipend, dpend;
    logic [AW-1:0] lock_addr;
    logic [3:0] grants;
    reset = 1'b0; inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    @(negedge clock);

    // Reset state, with a stray response that must be ignored.
    step("rst0");
    chk("rst0.bus_req", 64'(c_bus_req), 64'd0);
    bus_data_ok = 1'b1;
    step("rst1");
    bus_data_ok = 1'b0;
    reset = 1'b1;

    // Single load, response three cycles after acceptance.
    data_req = 1'b1; data_addr = 32'h1000_0004; data_size = 2'd2; bus_addr_ok = 1'b1;
    step("load");
    chk("load.addr_ok", 64'(c_data_addr_ok), 64'd1);
    chk("load.addr", 64'(c_bus_addr), 64'h1000_0004);
    data_req = 1'b0; bus_addr_ok = 1'b0;
    step("load_w1");
    step("load_w2");
    bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    step("load_rsp");
    chk("load.data_ok", 64'({c_data_data_ok, c_inst_data_ok}), 64'b10);
    bus_data_ok = 1'b0;

    // Contention: data first, then inst; responses in the same order.
    reset_pulse();
    inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h0000_0100;
    data_addr = 32'h2000_0000; bus_addr_ok = 1'b1;
    step("cont0");
    chk("cont0.data_first", 64'({c_data_addr_ok, c_inst_addr_ok}), 64'b10);
    data_req = 1'b0;
    step("cont1");
    chk("cont1.inst_next", 64'(c_inst_addr_ok), 64'd1);
    inst_req = 1'b0; bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1; bus_rdata = 32'hAAAA_0001;
    step("cont_rA");
    chk("cont.rA", 64'({c_data_data_ok, c_inst_data_ok}), 64'b10);
    bus_rdata = 32'hBBBB_0002;
    step("cont_rB");
    chk("cont.rB", 64'({c_data_data_ok, c_inst_data_ok}), 64'b01);
    bus_data_ok = 1'b0;

    // Lock hold: data stays granted while inst toggles.
    lock_addr = 32'h3000_0040;
    data_req = 1'b1; data_wr = 1'b1; data_wdata = 32'h1234_5678; data_addr = lock_addr;
    for (int i = 0; i < 4; i++) begin
      inst_req = i[0]; inst_addr = $urandom;
      step("lock");
      chk("lock.addr", 64'(c_bus_addr), 64'(lock_addr));
      chk("lock.no_ok", 64'(c_data_addr_ok), 64'd0);
    end
    inst_req = 1'b1;
    bus_addr_ok = 1'b1;
    step("lock5");
    chk("lock5.addr_ok", 64'({c_data_addr_ok, c_inst_addr_ok}), 64'b10);
    data_req = 1'b0; data_wr = 1'b0; inst_req = 1'b0; bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    step("lock_rsp");
    bus_data_ok = 1'b0;

    // Full FIFO: no issue while full, nor in the cycle a response frees a slot.
    inst_req = 1'b1; bus_addr_ok = 1'b1;
    step("full_a0");
    step("full_a1");
    step("full_blk");
    chk("full.blocked", 64'(c_bus_req), 64'd0);
    bus_data_ok = 1'b1;
    step("full_pop");
    chk("full.pop_noissue", 64'(c_bus_req), 64'd0);
    bus_data_ok = 1'b0;
    step("full_next");
    chk("full.next_issue", 64'(c_bus_req), 64'd1);
    inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
    step("full_d0");
    step("full_d1");
    bus_data_ok = 1'b0;

    // Both requests held for four accepts: grant order depends on RR.
    reset_pulse();
    inst_req = 1'b1; data_req = 1'b1; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("rr");
      grants[i] = c_data_addr_ok;
    end
    chk("rr.order", 64'(grants), RR ? 64'b0101 : 64'b1111);
    inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0;
    step("rr_d0");
    step("rr_d1");
    bus_data_ok = 1'b0;

    // Reset mid-flight drops the outstanding inst response.
    reset_pulse();
    inst_req = 1'b1; bus_addr_ok = 1'b1;
    step("mid_acc");
    inst_req = 1'b0; bus_addr_ok = 1'b0;
    reset_pulse();
    bus_data_ok = 1'b1;
    step("mid_rsp");
    chk("mid.no_data_ok", 64'({c_inst_data_ok, c_data_data_ok}), 64'b00);
    bus_data_ok = 1'b0;

    // Randomized traffic; requesters hold their fields until accepted.
    ipend = 1'b0; dpend = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!ipend && $urandom_range(0, 2) == 0) begin
        ipend = 1'b1; inst_req = 1'b1; inst_addr = $urandom;
      end
      if (!dpend && $urandom_range(0, 2) == 0) begin
        dpend = 1'b1; data_req = 1'b1; data_addr = $urandom; data_wdata = $urandom;
        data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 2));
      end
      bus_addr_ok = 1'($urandom_range(0, 1));
      bus_data_ok = ($urandom_range(0, 2) == 0);
      bus_rdata   = $urandom;
      reset       = ($urandom_range(0, 99) != 0);
      step("rnd");
      if (c_inst_addr_ok) begin ipend = 1'b0; inst_req = 1'b0; end
      if (c_data_addr_ok) begin dpend = 1'b0; data_req = 1'b0; end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
